// File: rtl/mbc7_pkg.sv
// -----------------------------------------------------------------------------
// mbc7_pkg
// Shared definitions for the MBC7 save-flush block.
// Contents:
//   flush_state_t        - flush FSM state encoding
//   EEPROM_BYTES         - size of the EEPROM image in bytes
//   SEG_BYTES            - bytes per dirty-map segment
//   SEG_COUNT            - number of dirty-map segments
//   DEFAULT_IDLE_TIMEOUT - quiet interval in ce_1x ticks before an automatic flush
// -----------------------------------------------------------------------------
package mbc7_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIET   = 3'd1,
        S_FETCH   = 3'd2,
        S_LATCH   = 3'd3,
        S_PRESENT = 3'd4
    } flush_state_t;

    localparam int EEPROM_BYTES         = 256;
    localparam int SEG_BYTES            = 16;
    localparam int SEG_COUNT            = EEPROM_BYTES / SEG_BYTES;
    localparam int DEFAULT_IDLE_TIMEOUT = 4194304;

endpackage

// File: rtl/mbc7_seg_pick.sv
// -----------------------------------------------------------------------------
// mbc7_seg_pick
// Combinational priority encoder over the 16-entry dirty-segment map. Returns
// the lowest marked segment whose index is at or above 'start'. Only
// instantiated when MBC7_SAVE_DIRTY_MAP_EN is defined.
// Ports:
//   seg_map  in  16  marked segments
//   start    in  4   lowest segment index to consider
//   seg      out 4   selected segment (0 when none)
//   none     out 1   no marked segment at or above start
// -----------------------------------------------------------------------------
module mbc7_seg_pick
    import mbc7_pkg::*;
(
    input  logic [SEG_COUNT-1:0] seg_map,
    input  logic [3:0]           start,
    output logic [3:0]           seg,
    output logic                 none
);

    // Scan from the top down so that the last hit is the lowest qualifying index.
    always_comb begin
        seg  = '0;
        none = 1'b1;
        for (int i = SEG_COUNT - 1; i >= 0; i--) begin
            if (seg_map[i] && (i >= int'(start))) begin
                seg  = 4'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mbc7_save_flush.sv
// -----------------------------------------------------------------------------
// mbc7_save_flush
// Watches MBC7 EEPROM backing-RAM writes, tracks dirty state and, after a
// programmable quiet interval or on host request, streams the EEPROM image out
// over a valid/ready byte stream for the save-file bridge.
//
// Optional feature macro: MBC7_SAVE_DIRTY_MAP_EN
//   defined   - a 16-bit map of dirty 16-byte segments is kept and a flush only
//               sends the marked segments (full image if the map is empty)
//   undefined - every flush sends bytes 0..255
//
// Parameters:
//   IDLE_TIMEOUT  quiet interval in ce_1x ticks before an automatic flush
//   TIMER_W       timer width, 2^TIMER_W > IDLE_TIMEOUT
// Ports:
//   clk_sys    in  1  system clock
//   reset      in  1  asynchronous active-high reset
//   enable     in  1  mapper selected; low clears everything synchronously
//   ce_1x      in  1  timer clock enable
//   cram_wr    in  1  EEPROM RAM write strobe (monitored)
//   cram_addr  in  8  EEPROM RAM write address (monitored)
//   flush_req  in  1  single-cycle immediate flush request
//   rd_addr    out 8  read address into the EEPROM RAM second port
//   rd_data    in  8  read data, one cycle after rd_addr
//   out_valid  out 1  stream byte valid
//   out_ready  in  1  consumer ready
//   out_addr   out 8  image offset of current byte
//   out_data   out 8  current byte
//   out_last   out 1  final byte of this flush
//   dirty      out 1  unflushed writes exist
//   busy       out 1  flush in progress
// -----------------------------------------------------------------------------
module mbc7_save_flush
    import mbc7_pkg::*;
#(
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
    parameter int TIMER_W      = 23
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic       ce_1x,
    input  logic       cram_wr,
    input  logic [7:0] cram_addr,
    input  logic       flush_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       dirty,
    output logic       busy
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(IDLE_TIMEOUT);
    localparam logic [7:0]         LAST_ADDR    = 8'(EEPROM_BYTES - 1);

    flush_state_t       state;
    logic [TIMER_W-1:0] timer;
    logic               pending;
    logic [7:0]         ptr;
    logic               valid_q;

    logic [7:0]         first_ptr;
    logic [7:0]         next_ptr;
    logic               at_last;
    logic               timer_expire;
    logic               flush_entry;

    // Expiry happens on the tick that would take the timer to zero; a write in
    // the same cycle reloads instead.
    assign timer_expire = (state == S_QUIET) && ce_1x && !cram_wr &&
                          (timer <= TIMER_W'(1));

    assign flush_entry  = enable &&
                          ((state == S_IDLE) || (state == S_QUIET)) &&
                          (flush_req || timer_expire);

    // enable low must kill the stream in the same cycle, before the
    // synchronous clear lands.
    assign out_valid = valid_q & enable;

`ifdef MBC7_SAVE_DIRTY_MAP_EN
    logic [SEG_COUNT-1:0] dirty_map;
    logic [SEG_COUNT-1:0] flush_map;
    logic [SEG_COUNT-1:0] entry_map;
    logic [3:0]           first_seg;
    logic [3:0]           next_seg;
    logic                 next_none;
    logic                 first_none_unused;
    logic                 unused_addr_bits;

    // An empty map means an explicit request for the whole image.
    assign entry_map = (dirty_map == '0) ? '1 : dirty_map;

    mbc7_seg_pick u_first_pick (
        .seg_map (entry_map),
        .start   (4'd0),
        .seg     (first_seg),
        .none    (first_none_unused)
    );

    mbc7_seg_pick u_next_pick (
        .seg_map (flush_map),
        .start   (ptr[7:4] + 4'd1),
        .seg     (next_seg),
        .none    (next_none)
    );

    assign first_ptr = {first_seg, 4'h0};
    assign next_ptr  = (ptr[3:0] != 4'hF) ? (ptr + 8'd1) : {next_seg, 4'h0};
    assign at_last   = (ptr[3:0] == 4'hF) && ((ptr[7:4] == 4'hF) || next_none);
    assign unused_addr_bits = ^cram_addr[3:0];

    // The snapshot taken at flush entry drives this flush; writes landing from
    // then on (including the entry cycle) accumulate for the follow-up flush.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dirty_map <= '0;
            flush_map <= '0;
        end else if (!enable) begin
            dirty_map <= '0;
            flush_map <= '0;
        end else begin
            if (flush_entry) begin
                flush_map <= entry_map;
                dirty_map <= '0;
            end
            if (cram_wr) begin
                dirty_map[cram_addr[7:4]] <= 1'b1;
            end
        end
    end
`else
    logic unused_addr;

    assign first_ptr   = 8'h00;
    assign next_ptr    = ptr + 8'd1;
    assign at_last     = (ptr == LAST_ADDR);
    assign unused_addr = ^cram_addr;
`endif

    // Main flush FSM. rd_addr is loaded on the way into FETCH so the RAM sees
    // it during FETCH and rd_data is ready for capture in LATCH.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            pending  <= 1'b0;
            ptr      <= '0;
            rd_addr  <= '0;
            out_addr <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            valid_q  <= 1'b0;
            dirty    <= 1'b0;
            busy     <= 1'b0;
        end else if (!enable) begin
            state    <= S_IDLE;
            timer    <= '0;
            pending  <= 1'b0;
            ptr      <= '0;
            rd_addr  <= '0;
            out_addr <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            valid_q  <= 1'b0;
            dirty    <= 1'b0;
            busy     <= 1'b0;
        end else if (flush_entry) begin
            // A write coinciding with entry is treated as a mid-flush write.
            state   <= S_FETCH;
            busy    <= 1'b1;
            dirty   <= cram_wr;
            pending <= cram_wr;
            ptr     <= first_ptr;
            rd_addr <= first_ptr;
        end else begin
            if (busy) begin
                if (cram_wr) begin
                    dirty   <= 1'b1;
                    pending <= 1'b1;
                end
                if (flush_req) begin
                    pending <= 1'b1;
                end
            end
            case (state)
                S_IDLE: begin
                    if (cram_wr) begin
                        dirty <= 1'b1;
                        timer <= TIMEOUT_LOAD;
                        state <= S_QUIET;
                    end
                end
                S_QUIET: begin
                    if (cram_wr) begin
                        dirty <= 1'b1;
                        timer <= TIMEOUT_LOAD;
                    end else if (ce_1x) begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    out_data <= rd_data;
                    out_addr <= ptr;
                    out_last <= at_last;
                    valid_q  <= 1'b1;
                    state    <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        valid_q  <= 1'b0;
                        out_last <= 1'b0;
                        if (out_last) begin
                            busy <= 1'b0;
                            // Anything that arrived mid-flush may have torn the
                            // image, so schedule a follow-up after a quiet interval.
                            if (pending || cram_wr || flush_req) begin
                                pending <= 1'b0;
                                timer   <= TIMEOUT_LOAD;
                                state   <= S_QUIET;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            ptr     <= next_ptr;
                            rd_addr <= next_ptr;
                            state   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbc7_save_flush.sv
// -----------------------------------------------------------------------------
// tb_mbc7_save_flush
// Self-checking bench for mbc7_save_flush. A behavioural model keeps the set of
// segments written since the last flush and turns it into the expected list of
// streamed offsets; stream bytes are compared against a RAM image kept here.
// Builds with or without MBC7_SAVE_DIRTY_MAP_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mbc7_save_flush;

    localparam int TIMEOUT = 8;
    localparam int TW      = 4;
`ifdef MBC7_SAVE_DIRTY_MAP_EN
    localparam logic [7:0] FIRST_ADDR = 8'h10;
`else
    localparam logic [7:0] FIRST_ADDR = 8'h00;
`endif

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       enable;
    logic       ce_1x;
    logic       cram_wr;
    logic [7:0] cram_addr;
    logic       flush_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_last;
    logic       dirty;
    logic       busy;

    mbc7_save_flush #(
        .IDLE_TIMEOUT (TIMEOUT),
        .TIMER_W      (TW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .ce_1x     (ce_1x),
        .cram_wr   (cram_wr),
        .cram_addr (cram_addr),
        .flush_req (flush_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .dirty     (dirty),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // EEPROM RAM second port: synchronous read, one cycle latency.
    logic [7:0] mem [256];
    always @(posedge clk_sys) rd_data <= mem[rd_addr];

    int          total = 0;
    int          bad   = 0;
    int          cyc_cnt = 0;
    int          ce_ticks = 0;
    bit          rand_ready = 1'b0;
    bit          hold = 1'b0;
    logic [7:0]  h_addr;
    logic [7:0]  h_data;
    logic        h_last;
    int          stab_err = 0;
    int          cap_addr[$];
    int          cap_data[$];
    int          cap_last[$];
    bit          got_last = 1'b0;
    logic [15:0] model_map = 16'h0;
    int          exp_q[$];

    typedef struct {
        bit         en;
        bit         wr;
        logic [7:0] addr;
        bit         fr;
        bit         rdy;
        bit         exp_valid;
        bit         exp_busy;
        bit         exp_dirty;
        bit         chk_addr;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One clk_sys cycle: observe this cycle's outputs, take the edge, then
    // update free-running inputs 1 ns after the edge.
    task automatic cycle();
        if (out_valid && out_ready) begin
            cap_addr.push_back(int'(out_addr));
            cap_data.push_back(int'(out_data));
            cap_last.push_back(int'(out_last));
            if (out_last) got_last = 1'b1;
        end
        if (hold && !(out_valid === 1'b1 && out_addr === h_addr &&
                      out_data === h_data && out_last === h_last)) begin
            stab_err++;
        end
        hold   = out_valid && !out_ready;
        h_addr = out_addr;
        h_data = out_data;
        h_last = out_last;
        if (ce_1x) ce_ticks++;
        @(posedge clk_sys);
        #1;
        cyc_cnt++;
        ce_1x = ((cyc_cnt % 4) == 0);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Expected offsets for a flush given the segments written since the last one.
    function automatic void build_expected(input logic [15:0] m);
        logic [15:0] sel;
        exp_q.delete();
`ifdef MBC7_SAVE_DIRTY_MAP_EN
        sel = (m == 16'h0) ? 16'hFFFF : m;
`else
        sel = m | 16'hFFFF;
`endif
        for (int s = 0; s < 16; s++) begin
            if (sel[s]) begin
                for (int k = 0; k < 16; k++) exp_q.push_back(s * 16 + k);
            end
        end
    endfunction

    task automatic pulse_wr(input logic [7:0] a);
        mem[a] = 8'($urandom);
        model_map[a[7:4]] = 1'b1;
        cram_wr   = 1'b1;
        cram_addr = a;
        cycle();
        cram_wr   = 1'b0;
        ce_ticks  = 0;
    endtask

    task automatic pulse_flush();
        build_expected(model_map);
        model_map = 16'h0;
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
    endtask

    task automatic expect_auto();
        build_expected(model_map);
        model_map = 16'h0;
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("flush_start", int'(busy), 1);
    endtask

    // Collect one flush and compare it with exp_q / mem. Optionally injects a
    // write once wr_at bytes have been accepted.
    task automatic run_flush(input int wr_at, input logic [7:0] wr_a, input int budget);
        int n;
        bit done_wr;
        int addr_err;
        int data_err;
        int last_err;
        int lim;
        n = 0; done_wr = 1'b0; addr_err = 0; data_err = 0; last_err = 0;
        cap_addr.delete(); cap_data.delete(); cap_last.delete();
        got_last = 1'b0; stab_err = 0; hold = 1'b0;
        while (!got_last && n < budget) begin
            if (wr_at >= 0 && !done_wr && cap_addr.size() == wr_at) begin
                cram_wr   = 1'b1;
                cram_addr = wr_a;
                model_map[wr_a[7:4]] = 1'b1;
                done_wr   = 1'b1;
            end
            cycle();
            cram_wr = 1'b0;
            n++;
        end
        checkOutput("flush_done", int'(got_last), 1);
        checkOutput("byte_count", cap_addr.size(), exp_q.size());
        lim = (cap_addr.size() < exp_q.size()) ? cap_addr.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            if (cap_addr[i] != exp_q[i]) addr_err++;
            if (cap_data[i] != int'(mem[exp_q[i]])) data_err++;
            if (cap_last[i] != ((i == exp_q.size() - 1) ? 1 : 0)) last_err++;
        end
        checkOutput("addr_seq", addr_err, 0);
        checkOutput("data_match", data_err, 0);
        checkOutput("last_flag", last_err, 0);
        checkOutput("hold_stable", stab_err, 0);
        checkOutput("busy_after", int'(busy), 0);
    endtask

    // Apply one table vector for a single cycle.
    task automatic applyStimulus(input vec_t v);
        enable    = v.en;
        cram_wr   = v.wr;
        cram_addr = v.addr;
        flush_req = v.fr;
        out_ready = v.rdy;
        cycle();
        cram_wr   = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        reset     = 1'b0;
        enable    = 1'b1;
        hold      = 1'b0;
        model_map = 16'h0;
    endtask

    initial begin
        int early;
        int nw;
        int n;

        //            en  wr  addr   fr  rdy  v   b   d   ca  exp_addr
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, FIRST_ADDR};
        vecs[6] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FIRST_ADDR};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, FIRST_ADDR};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        reset = 1'b1; enable = 1'b1; ce_1x = 1'b0; cram_wr = 1'b0; cram_addr = 8'h00;
        flush_req = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk_sys);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_dirty", int'(dirty), 0);
        checkOutput("rst_last", int'(out_last), 0);
        checkOutput("rst_rd_addr", int'(rd_addr), 0);
        checkOutput("rst_out_addr", int'(out_addr), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        reset = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_dirty", i), int'(dirty), int'(vecs[i].exp_dirty));
            if (vecs[i].chk_addr) begin
                checkOutput($sformatf("vec%0d_addr", i), int'(out_addr), int'(vecs[i].exp_addr));
            end
        end
        do_reset();

        $display("[TB] single write then automatic flush");
        rand_ready = 1'b0; out_ready = 1'b1;
        pulse_wr(8'h10);
        expect_auto();
        wait_busy(200);
        checkOutput("timeout_ticks", ce_ticks, TIMEOUT);
        run_flush(-1, 8'h00, 4000);

        $display("[TB] writes every 5 ticks hold off the flush");
        early = 0;
        for (int w = 0; w < 6; w++) begin
            pulse_wr(8'($urandom));
            if (w < 5) begin
                n = 0;
                while (ce_ticks < 5 && n < 100) begin
                    cycle();
                    if (busy) early++;
                    n++;
                end
            end
        end
        checkOutput("no_early_flush", early, 0);
        expect_auto();
        wait_busy(200);
        checkOutput("timeout_after_last", ce_ticks, TIMEOUT);
        run_flush(-1, 8'h00, 4000);

        $display("[TB] random ready with write at byte 100");
        rand_ready = 1'b1;
        pulse_flush();
        run_flush(100, 8'h10, 4000);
        ce_ticks = 0;
        checkOutput("dirty_kept", int'(dirty), 1);
        expect_auto();
        wait_busy(200);
        checkOutput("followup_ticks", ce_ticks, TIMEOUT);
        run_flush(-1, 8'h00, 4000);
        checkOutput("clean_followup", int'(dirty), 0);

        $display("[TB] segment selection writes 0x05 and 0xE2");
        rand_ready = 1'b0; out_ready = 1'b1;
        pulse_wr(8'h05);
        pulse_wr(8'hE2);
        pulse_flush();
        run_flush(-1, 8'h00, 4000);
        pulse_flush();
        run_flush(-1, 8'h00, 4000);

        $display("[TB] randomized rounds");
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                pulse_wr(8'($urandom));
                repeat ($urandom_range(0, 12)) cycle();
            end
            if (nw == 0 || $urandom_range(0, 1) == 1) begin
                pulse_flush();
            end else begin
                expect_auto();
                wait_busy(200);
                checkOutput("rand_ticks", ce_ticks, TIMEOUT);
            end
            run_flush(-1, 8'h00, 4000);
            checkOutput("rand_clean", int'(dirty), 0);
        end

        $display("[TB] reset while presenting byte 0x37");
        rand_ready = 1'b0; out_ready = 1'b1;
        pulse_flush();
        pulse_wr(8'h20);
        n = 0;
        while (!(out_valid && out_addr == 8'h37) && n < 2000) begin
            cycle();
            n++;
        end
        checkOutput("reach_37", int'(out_valid && out_addr == 8'h37), 1);
        checkOutput("dirty_before_rst", int'(dirty), 1);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", int'(out_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_dirty", int'(dirty), 0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0; out_ready = 1'b1; hold = 1'b0; model_map = 16'h0;
        pulse_flush();
        checkOutput("post_rst_busy", int'(busy), 1);
        checkOutput("post_rst_fetch_valid", int'(out_valid), 0);
        cycle();
        checkOutput("post_rst_latch_valid", int'(out_valid), 0);
        cycle();
        checkOutput("post_rst_present_valid", int'(out_valid), 1);
        checkOutput("post_rst_first_addr", int'(out_addr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbc7_save_flush.md
# mbc7_save_flush

Downstream companion to the MBC7 EEPROM emulation. It watches EEPROM backing-RAM writes, tracks dirty state, and once the EEPROM has been quiet for a programmable interval (or on host request) streams the 256-byte EEPROM image out over a valid/ready byte stream. The save-file bridge consumes that stream, so battery saves reach the host without polling the whole image.

## Interface
Parameters:
- IDLE_TIMEOUT, 4194304: quiet interval in ce_1x ticks (about 1 s at 4 MHz) before an automatic flush.
- TIMER_W, 23: timer width; must satisfy 2^TIMER_W > IDLE_TIMEOUT.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  MBC7 mapper selected; low acts as a synchronous clear.
- ce_1x  in  1  4 MHz clock enable; used only for the timer.
- cram_wr  in  1  EEPROM backing-RAM write strobe (monitor only).
- cram_addr  in  8  EEPROM backing-RAM write address (monitor only).
- flush_req  in  1  single-cycle host request for an immediate flush.
- rd_addr  out  8  address on the second read port of the EEPROM RAM.
- rd_data  in  8  read data, valid exactly one clk_sys cycle after rd_addr.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  consumer ready.
- out_addr  out  8  image offset of the current byte.
- out_data  out  8  byte value.
- out_last  out  1  final byte of this flush.
- dirty  out  1  unflushed writes exist.
- busy  out  1  a flush is in progress.

## Operation
- All outputs reset to 0. This includes rd_addr, out_addr and out_data. The timer, the pending flag and the dirty map also reset to 0.
- enable=0 has the same effect as reset, but applied synchronously. A flush in progress is abandoned and out_valid drops the same cycle.
- FSM states: IDLE, QUIET, FETCH, LATCH, PRESENT.
- IDLE:
  - cram_wr sets dirty, loads the timer with IDLE_TIMEOUT, and goes to QUIET.
  - flush_req goes to FETCH, even when dirty=0.
- QUIET:
  - On each ce_1x the timer decrements.
  - cram_wr reloads the timer. It wins over expiry in the same cycle.
  - Timer reaching 0 goes to FETCH.
  - flush_req goes to FETCH immediately.
- FETCH: drive rd_addr with the current pointer, then go to LATCH.
- LATCH: capture rd_data into out_data, set out_addr to the pointer, then go to PRESENT.
- PRESENT:
  - out_valid=1. out_addr, out_data and out_last are held stable until out_ready.
  - On valid&ready with last=0: advance the pointer and go to FETCH.
  - On valid&ready with last=1: go to IDLE.
- Entering FETCH from IDLE or QUIET:
  - clears dirty and the pending flag;
  - sets busy;
  - sets the pointer to the first byte to send.
- busy is high in FETCH, LATCH and PRESENT.
- cram_wr during a flush: set dirty and pending; the current flush still completes.
- On return to IDLE with pending=1: load the timer and enter QUIET instead. The image may have been torn mid-flush, so a follow-up flush is guaranteed.
- flush_req during a flush: set pending. It does not restart the stream.
- Pointer arithmetic is 8-bit. In full-image mode out_last is asserted when the pointer is 255.

## Timing
- Read path is one byte every 3 cycles plus consumer stall: FETCH, LATCH, PRESENT.
- First out_valid comes 3 cycles after the flush trigger cycle. Full image: minimum 768 cycles.
- out_valid never deasserts without a handshake, except on reset or enable=0.
- Timer decrement is gated by ce_1x. cram_wr and flush_req are sampled every clk_sys cycle.

## Configuration
- MBC7_SAVE_DIRTY_MAP_EN defined:
  - A 16-bit map records dirty 16-byte segments, indexed by cram_addr[7:4].
  - A flush sends only the marked segments, in ascending order, 16 bytes each.
  - out_last is asserted on the last byte of the highest marked segment.
  - The map is cleared on flush entry; writes during the flush set bits for the follow-up flush.
  - flush_req with an empty map sends the full image.
- MBC7_SAVE_DIRTY_MAP_EN undefined: no map is built, and every flush sends bytes 0 to 255.

## Structure
- Shared package mbc7_pkg holds:
  - the FSM state enum;
  - EEPROM_BYTES=256;
  - SEG_BYTES=16;
  - the default IDLE_TIMEOUT.
- Sub-module mbc7_seg_pick: combinational priority encoder returning the next set segment at or above a given index, plus a none-left flag. It is used only when the macro is defined.

## Test plan
- Reset mid-PRESENT, with out_valid=1 at byte 0x37: out_valid, busy and dirty are 0 the same cycle, and the FSM is in IDLE.
- Single cram_wr at addr 0x10 with IDLE_TIMEOUT=8:
  - after 8 ce_1x ticks, 256 bytes stream at offsets 0 to 255;
  - out_last is set only at 255;
  - out_data equals the RAM model byte for byte.
- Writes every 5 ce ticks with IDLE_TIMEOUT=8: no flush starts while the writes continue; the flush starts 8 ticks after the last write.
- out_ready toggling randomly: no byte is dropped or duplicated, and out_addr/out_data are stable while valid&!ready.
- cram_wr at byte 100 of an active flush:
  - the flush completes to 255;
  - dirty stays 1;
  - a second full flush begins IDLE_TIMEOUT ticks later.
- Macro defined, writes to 0x05 and 0xE2:
  - a flush sends exactly 0x00–0x0F then 0xE0–0xEF, with out_last at 0xEF;
  - flush_req with no dirty segments sends 0 to 255.
